// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: decode->execute and execute->memory bundles,
// ALU opcodes, branch and M-extension func3 encodings, and the mul/div FSM states.
package pipeline_types;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB, ALU_ADDPC
    } alu_op_e;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_e;

    localparam logic [2:0] MD_MUL_F3 = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3;
    localparam logic [2:0] MD_DIV_F3 = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7;

    localparam logic [2:0] BR_BEQ = 3'd0, BR_BNE = 3'd1, BR_BLT = 3'd4;
    localparam logic [2:0] BR_BGE = 3'd5, BR_BLTU = 3'd6, BR_BGEU = 3'd7;

    typedef struct packed {
        logic       valid;
        alu_op_e    alu_op;
        logic       alu_src_imm;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       is_md;
        logic [2:0] func3;
        logic       mem_en;
        logic       wb_en;
    } ex_ctrl_t;

    typedef struct packed { logic [XLEN_DEF-1:0] value; } src_t;
    typedef struct packed { logic [4:0] addr; } dst_t;

    typedef struct packed {
        ex_ctrl_t            ctrl;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] imm;
        src_t                rs1;
        src_t                rs2;
        dst_t                rd;
    } id_ex_t;

    typedef struct packed {
        logic       valid;
        logic       mem_en;
        logic       wb_en;
        logic [2:0] func3;
    } me_ctrl_t;

    typedef struct packed {
        logic [4:0]          addr;
        logic [XLEN_DEF-1:0] value;
    } rd_t;

    typedef struct packed {
        me_ctrl_t ctrl;
        rd_t      rd;
        src_t     rs;
    } ex_mem_t;

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Multi-cycle M-extension unit: one registered multiply cycle, or a 32-step
// restoring divide on magnitudes with the signs applied on the last step.
module muldiv_unit
    import pipeline_types::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            iClk,
    input  logic            nRst,
    input  logic            start,
    input  logic            flush,
    input  logic            hold,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e state, stateNext;
    logic [2:0]      opReg;
    logic [XLEN-1:0] aReg, bReg, rReg;
    logic            negQ, negR;
    logic [CW-1:0]   cnt;

    logic divSigned, divByZero, divOvf, divSpecial;
    logic [2*XLEN-1:0] prodU;
    logic [XLEN-1:0]   prodHi;
    logic              aNegM, bNegM;
    logic [XLEN:0]     remShift;
    logic              remGe;
    logic [XLEN-1:0]   remNext, quoNext;

    assign divSigned  = ~op[0];
    assign divByZero  = (b == '0);
    assign divOvf     = divSigned & (a == MINV) & (b == '1);
    assign divSpecial = divByZero | divOvf;

    // Unsigned product, then subtract the cross terms of whichever operands are signed
    assign prodU  = {{XLEN{1'b0}}, aReg} * {{XLEN{1'b0}}, bReg};
    assign aNegM  = aReg[XLEN-1] & ((opReg == MD_MULH) | (opReg == MD_MULHSU));
    assign bNegM  = bReg[XLEN-1] & (opReg == MD_MULH);
    assign prodHi = prodU[2*XLEN-1:XLEN] - (aNegM ? bReg : '0) - (bNegM ? aReg : '0);

    assign remShift = {rReg, aReg[XLEN-1]};
    assign remGe    = remShift >= {1'b0, bReg};
    assign remNext  = remGe ? XLEN'(remShift - {1'b0, bReg}) : remShift[XLEN-1:0];
    assign quoNext  = {aReg[XLEN-2:0], remGe};

    assign done = (state == MD_DONE);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) state <= MD_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        unique case (state)
            MD_IDLE: begin
                busy = start;
                if (start) begin
                    if (!op[2])          stateNext = MD_MUL;
                    else if (divSpecial) stateNext = MD_DONE;
                    else                 stateNext = MD_DIV;
                end
            end
            MD_MUL: begin
                busy      = 1'b1;
                stateNext = MD_DONE;
            end
            MD_DIV: begin
                busy = 1'b1;
                if (cnt == LAST) stateNext = MD_DONE;
            end
            MD_DONE: begin
                if (!hold) stateNext = MD_IDLE;
            end
            default: stateNext = MD_IDLE;
        endcase
        if (flush) stateNext = MD_IDLE;
    end

    // aReg doubles as the dividend/quotient shift register during a divide
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            opReg  <= '0;
            aReg   <= '0;
            bReg   <= '0;
            rReg   <= '0;
            negQ   <= 1'b0;
            negR   <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (!flush) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        opReg <= op;
                        aReg  <= a;
                        bReg  <= b;
                        rReg  <= '0;
                        cnt   <= '0;
                        negQ  <= divSigned & (a[XLEN-1] ^ b[XLEN-1]);
                        negR  <= divSigned & a[XLEN-1];
                        if (op[2]) begin
                            if (divByZero) begin
                                result <= op[1] ? a : '1;
                            end else if (divOvf) begin
                                result <= op[1] ? '0 : MINV;
                            end else begin
                                aReg <= (divSigned & a[XLEN-1]) ? -a : a;
                                bReg <= (divSigned & b[XLEN-1]) ? -b : b;
                            end
                        end
                    end
                end
                MD_MUL: result <= (opReg == MD_MUL_F3) ? prodU[XLEN-1:0] : prodHi;
                MD_DIV: begin
                    aReg <= quoNext;
                    rReg <= remNext;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        if (opReg[1]) result <= negR ? -remNext : remNext;
                        else          result <= negQ ? -quoNext : quoNext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, address generation, branch resolution and the EX/MEM
// register; M-extension ops are handed to muldiv_unit and stall upstream.
module ex_stage
    import pipeline_types::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            iClk,
    input  logic            nRst,
    input  logic            iEn,
    input  logic            iStall,
    input  logic            iFlush,
    input  id_ex_t          iID,
    output ex_mem_t         oME,
    output logic            oStall,
    output logic            oBranch,
    output logic [XLEN-1:0] oTarget
);

    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] opA, opB, aluRes, addrSum, pcRel, linkAddr, mdResult;
    logic [SW-1:0]   shamt;
    logic            brTrue, jump, redirect, mdStart, mdBusy, mdDone;
    ex_mem_t         meNext;

    assign opA      = (iID.ctrl.alu_op == ALU_ADDPC) ? iID.pc : iID.rs1.value;
    assign opB      = iID.ctrl.alu_src_imm ? iID.imm : iID.rs2.value;
    assign shamt    = opB[SW-1:0];
    assign addrSum  = iID.rs1.value + iID.imm;
    assign pcRel    = iID.pc + iID.imm;
    assign linkAddr = iID.pc + XLEN'(4);
    assign jump     = iID.ctrl.is_jal | iID.ctrl.is_jalr;
    assign mdStart  = iID.ctrl.valid & iID.ctrl.is_md & iEn;

    always_comb begin
        aluRes = '0;
        case (iID.ctrl.alu_op)
            ALU_ADD, ALU_ADDPC: aluRes = opA + opB;
            ALU_SUB:   aluRes = opA - opB;
            ALU_SLL:   aluRes = opA << shamt;
            ALU_SLT:   aluRes = {{(XLEN-1){1'b0}}, $signed(opA) < $signed(opB)};
            ALU_SLTU:  aluRes = {{(XLEN-1){1'b0}}, opA < opB};
            ALU_XOR:   aluRes = opA ^ opB;
            ALU_SRL:   aluRes = opA >> shamt;
            ALU_SRA:   aluRes = $signed(opA) >>> shamt;
            ALU_OR:    aluRes = opA | opB;
            ALU_AND:   aluRes = opA & opB;
            ALU_PASSB: aluRes = opB;
            default:   aluRes = '0;
        endcase
    end

    always_comb begin
        brTrue = 1'b0;
        case (iID.ctrl.func3)
            BR_BEQ:  brTrue = iID.rs1.value == iID.rs2.value;
            BR_BNE:  brTrue = iID.rs1.value != iID.rs2.value;
            BR_BLT:  brTrue = $signed(iID.rs1.value) <  $signed(iID.rs2.value);
            BR_BGE:  brTrue = $signed(iID.rs1.value) >= $signed(iID.rs2.value);
            BR_BLTU: brTrue = iID.rs1.value <  iID.rs2.value;
            BR_BGEU: brTrue = iID.rs1.value >= iID.rs2.value;
            default: brTrue = 1'b0;
        endcase
    end

    // Redirect only when this instruction actually advances out of the stage
    assign redirect = (jump | (iID.ctrl.is_branch & brTrue)) & iID.ctrl.valid & iEn
                      & ~iStall & ~mdBusy;
    assign oBranch  = nRst & redirect;
    assign oTarget  = !nRst ? '0
                    : iID.ctrl.is_jalr ? (addrSum & ~{{(XLEN-1){1'b0}}, 1'b1}) : pcRel;
    assign oStall   = nRst & mdBusy;

    muldiv_unit #(.XLEN(XLEN)) uMulDiv (
        .iClk   (iClk),
        .nRst   (nRst),
        .start  (mdStart),
        .flush  (iFlush),
        .hold   (iStall),
        .op     (iID.ctrl.func3),
        .a      (iID.rs1.value),
        .b      (iID.rs2.value),
        .busy   (mdBusy),
        .done   (mdDone),
        .result (mdResult)
    );

    always_comb begin
        meNext              = '0;
        meNext.ctrl.valid   = iID.ctrl.valid & iEn;
        meNext.ctrl.mem_en  = iID.ctrl.mem_en;
        meNext.ctrl.wb_en   = iID.ctrl.wb_en;
        meNext.ctrl.func3   = iID.ctrl.func3;
        meNext.rd.addr      = iID.rd.addr;
        meNext.rs.value     = iID.rs2.value;
        if (iID.ctrl.is_md)      meNext.rd.value = mdDone ? mdResult : '0;
        else if (jump)           meNext.rd.value = linkAddr;
        else if (iID.ctrl.mem_en) meNext.rd.value = addrSum;
        else                     meNext.rd.value = aluRes;
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst)                     oME <= '0;
        else if (iFlush)               oME <= '0;
        else if (!(iStall || mdBusy))  oME <= meNext;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a vector table for single-cycle ops and branches,
// plus hand sequences for mul/div latency, stall hold, flush and reset.
module tb_ex_stage;
    import pipeline_types::*;

    logic    iClk = 1'b0;
    logic    nRst, iEn, iStall, iFlush;
    id_ex_t  iID;
    ex_mem_t oME;
    logic    oStall, oBranch;
    logic [31:0] oTarget;

    int nChecks = 0;
    int nFail   = 0;

    typedef struct {
        id_ex_t      id;
        logic        en;
        logic        chkRd;
        logic [31:0] expRd;
        logic        expBr;
        logic [31:0] expTgt;
    } vec_t;
    vec_t vecs[$];

    ex_stage dut (
        .iClk    (iClk),
        .nRst    (nRst),
        .iEn     (iEn),
        .iStall  (iStall),
        .iFlush  (iFlush),
        .iID     (iID),
        .oME     (oME),
        .oStall  (oStall),
        .oBranch (oBranch),
        .oTarget (oTarget)
    );

    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic id_ex_t mkId(input alu_op_e op, input logic srcImm,
                                    input logic [31:0] pc, input logic [31:0] imm,
                                    input logic [31:0] rs1, input logic [31:0] rs2);
        id_ex_t v;
        v = '0;
        v.ctrl.valid       = 1'b1;
        v.ctrl.alu_op      = op;
        v.ctrl.alu_src_imm = srcImm;
        v.ctrl.wb_en       = 1'b1;
        v.pc        = pc;
        v.imm       = imm;
        v.rs1.value = rs1;
        v.rs2.value = rs2;
        v.rd.addr   = 5'd5;
        return v;
    endfunction

    function automatic id_ex_t mkBr(input logic [2:0] f3, input logic [31:0] pc,
                                    input logic [31:0] imm, input logic [31:0] rs1,
                                    input logic [31:0] rs2);
        id_ex_t v;
        v = mkId(ALU_SUB, 1'b0, pc, imm, rs1, rs2);
        v.ctrl.is_branch = 1'b1;
        v.ctrl.wb_en     = 1'b0;
        v.ctrl.func3     = f3;
        return v;
    endfunction

    function automatic id_ex_t mkMd(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
        id_ex_t v;
        v = mkId(ALU_ADD, 1'b0, 32'h0, 32'h0, a, b);
        v.ctrl.is_md = 1'b1;
        v.ctrl.func3 = f3;
        return v;
    endfunction

    task automatic addVec(input id_ex_t id, input logic en, input logic chkRd,
                          input logic [31:0] expRd, input logic expBr,
                          input logic [31:0] expTgt);
        vec_t t;
        t.id = id; t.en = en; t.chkRd = chkRd; t.expRd = expRd;
        t.expBr = expBr; t.expTgt = expTgt;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input id_ex_t v, input logic en);
        @(negedge iClk);
        iID = v;
        iEn = en;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one md op to completion, counting the cycles oStall stays high
    task automatic runMd(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input int expStall, input logic [31:0] expRes);
        int n;
        applyStimulus(mkMd(f3, a, b), 1'b1);
        #1;
        n = 0;
        while (oStall && n < 200) begin
            n++;
            @(negedge iClk);
            #1;
        end
        checkOutput({name, ".stalls"}, n, expStall);
        @(posedge iClk);
        #1;
        checkOutput({name, ".valid"}, oME.ctrl.valid, 1'b1);
        checkOutput({name, ".result"}, oME.rd.value, expRes);
        applyStimulus('0, 1'b1);
    endtask

    initial begin
        id_ex_t st, ld, jal, jalr, bub;
        ex_mem_t expHeld;
        int n;

        nRst = 1'b0; iEn = 1'b1; iStall = 1'b0; iFlush = 1'b0; iID = '0;
        #3;
        checkOutput("reset.oME", oME, 0);
        checkOutput("reset.oStall", oStall, 0);
        checkOutput("reset.oBranch", oBranch, 0);
        checkOutput("reset.oTarget", oTarget, 0);
        @(negedge iClk);
        nRst = 1'b1;

        addVec(mkId(ALU_ADD,   1'b0, 0, 0, 5, 7), 1, 1, 32'd12, 0, 0);
        addVec(mkId(ALU_SRA,   1'b1, 0, 4, 32'h8000_0000, 0), 1, 1, 32'hF800_0000, 0, 0);
        addVec(mkId(ALU_SUB,   1'b0, 0, 0, 5, 7), 1, 1, 32'hFFFF_FFFE, 0, 0);
        addVec(mkId(ALU_SLT,   1'b0, 0, 0, 32'hFFFF_FFFF, 1), 1, 1, 32'd1, 0, 0);
        addVec(mkId(ALU_SLTU,  1'b0, 0, 0, 32'hFFFF_FFFF, 1), 1, 1, 32'd0, 0, 0);
        addVec(mkId(ALU_XOR,   1'b0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00), 1, 1, 32'h0FF0_0FF0, 0, 0);
        addVec(mkId(ALU_OR,    1'b0, 0, 0, 32'hF0F0_F0F0, 32'h0F0F_0000), 1, 1, 32'hFFFF_F0F0, 0, 0);
        addVec(mkId(ALU_AND,   1'b0, 0, 0, 32'hF0F0_F0F0, 32'hFF00_FF00), 1, 1, 32'hF000_F000, 0, 0);
        addVec(mkId(ALU_SLL,   1'b0, 0, 0, 1, 32'h3F), 1, 1, 32'h8000_0000, 0, 0);
        addVec(mkId(ALU_SRL,   1'b1, 0, 4, 32'h8000_0000, 0), 1, 1, 32'h0800_0000, 0, 0);
        addVec(mkId(ALU_PASSB, 1'b1, 0, 32'h1234_5000, 32'hFFFF, 0), 1, 1, 32'h1234_5000, 0, 0);
        addVec(mkId(ALU_ADDPC, 1'b1, 32'h100, 32'h1000, 32'h5555, 0), 1, 1, 32'h1100, 0, 0);
        addVec(mkBr(BR_BEQ,  32'h100, 32'h20, 9, 9), 1, 0, 0, 1, 32'h120);
        addVec(mkBr(BR_BNE,  32'h100, 32'h20, 9, 9), 1, 0, 0, 0, 0);
        addVec(mkBr(BR_BLT,  32'h200, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1), 1, 0, 0, 1, 32'h1F0);
        addVec(mkBr(BR_BGE,  32'h200, 32'h10, 32'hFFFF_FFFF, 1), 1, 0, 0, 0, 0);
        addVec(mkBr(BR_BLTU, 32'h80, 32'h8, 1, 32'hFFFF_FFFF), 1, 0, 0, 1, 32'h88);
        addVec(mkBr(BR_BGEU, 32'h80, 32'h8, 1, 32'hFFFF_FFFF), 1, 0, 0, 0, 0);
        jal = mkId(ALU_ADD, 1'b0, 32'h300, 32'h40, 0, 0);
        jal.ctrl.is_jal = 1'b1;
        addVec(jal, 1, 1, 32'h304, 1, 32'h340);
        jalr = mkId(ALU_ADD, 1'b1, 32'h400, 32'h0, 32'h203, 0);
        jalr.ctrl.is_jalr = 1'b1;
        addVec(jalr, 1, 1, 32'h404, 1, 32'h202);
        st = mkId(ALU_ADD, 1'b1, 0, 8, 32'h1000, 32'hDEAD_BEEF);
        st.ctrl.mem_en = 1'b1; st.ctrl.wb_en = 1'b0; st.ctrl.func3 = 3'd2;
        addVec(st, 1, 1, 32'h1008, 0, 0);
        ld = mkId(ALU_ADD, 1'b1, 0, 32'hFFFF_FFFC, 32'h2000, 32'h77);
        ld.ctrl.mem_en = 1'b1;
        addVec(ld, 1, 1, 32'h1FFC, 0, 0);
        addVec(mkBr(BR_BEQ, 32'h100, 32'h20, 9, 9), 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].id, vecs[i].en);
            #1;
            checkOutput($sformatf("v%0d.oBranch", i), oBranch, vecs[i].expBr);
            if (vecs[i].expBr) checkOutput($sformatf("v%0d.oTarget", i), oTarget, vecs[i].expTgt);
            @(posedge iClk);
            #1;
            checkOutput($sformatf("v%0d.valid", i), oME.ctrl.valid, vecs[i].en);
            if (vecs[i].chkRd) checkOutput($sformatf("v%0d.rd", i), oME.rd.value, vecs[i].expRd);
            checkOutput($sformatf("v%0d.rs", i), oME.rs.value, vecs[i].id.rs2.value);
            checkOutput($sformatf("v%0d.memwb", i), {oME.ctrl.mem_en, oME.ctrl.wb_en},
                        {vecs[i].id.ctrl.mem_en, vecs[i].id.ctrl.wb_en});
        end

        runMd("div",    MD_DIV_F3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD);
        runMd("rem",    MD_REM,    32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
        runMd("divovf", MD_DIV_F3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        runMd("divu0",  MD_DIVU,   32'h1234, 32'd0, 1, 32'hFFFF_FFFF);
        runMd("remu0",  MD_REMU,   32'h1234, 32'd0, 1, 32'h1234);
        runMd("divu",   MD_DIVU,   32'd100, 32'd7, 33, 32'd14);
        runMd("remu",   MD_REMU,   32'd100, 32'd7, 33, 32'd2);
        runMd("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        runMd("mul",    MD_MUL_F3, 32'd7, 32'hFFFF_FFFD, 2, 32'hFFFF_FFEB);
        runMd("mulh",   MD_MULH,   32'h8000_0000, 32'd2, 2, 32'hFFFF_FFFF);
        runMd("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF);

        // MULHU result must survive an external stall held in DONE
        applyStimulus(mkId(ALU_ADD, 1'b0, 0, 0, 1, 2), 1'b1);
        expHeld = '0;
        expHeld.ctrl.valid = 1'b1; expHeld.ctrl.wb_en = 1'b1;
        expHeld.rd.addr = 5'd5; expHeld.rd.value = 32'd3; expHeld.rs.value = 32'd2;
        applyStimulus(mkMd(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1);
        #1;
        n = 0;
        while (oStall && n < 20) begin
            n++;
            @(negedge iClk);
            #1;
        end
        checkOutput("hold.stalls", n, 2);
        iStall = 1'b1;
        repeat (5) begin
            @(posedge iClk);
            #1;
            checkOutput("hold.oME", oME, expHeld);
            checkOutput("hold.oStall", oStall, 0);
        end
        @(negedge iClk);
        iStall = 1'b0;
        @(posedge iClk);
        #1;
        checkOutput("hold.result", oME.rd.value, 32'hFFFF_FFFE);
        applyStimulus('0, 1'b1);

        // Flush ten cycles into a divide
        applyStimulus(mkId(ALU_ADD, 1'b0, 0, 0, 1, 2), 1'b1);
        applyStimulus(mkMd(MD_DIVU, 32'd100, 32'd7), 1'b1);
        repeat (10) @(negedge iClk);
        #1;
        checkOutput("flush.busyBefore", oStall, 1);
        iFlush = 1'b1;
        iID = '0;
        @(posedge iClk);
        #1;
        checkOutput("flush.oME", oME, 0);
        checkOutput("flush.oStall", oStall, 0);
        @(negedge iClk);
        iFlush = 1'b0;
        applyStimulus(mkId(ALU_ADD, 1'b0, 0, 0, 3, 4), 1'b1);
        @(posedge iClk);
        #1;
        checkOutput("flush.addRd", oME.rd.value, 32'd7);
        checkOutput("flush.addValid", oME.ctrl.valid, 1);

        // Asynchronous reset in the middle of a divide
        applyStimulus(mkId(ALU_ADD, 1'b0, 0, 0, 1, 2), 1'b1);
        applyStimulus(mkMd(MD_DIV_F3, 32'hFFFF_FFF9, 32'd2), 1'b1);
        repeat (5) @(negedge iClk);
        #2;
        nRst = 1'b0;
        #1;
        checkOutput("rstmid.oME", oME, 0);
        checkOutput("rstmid.oStall", oStall, 0);
        checkOutput("rstmid.oBranch", oBranch, 0);
        checkOutput("rstmid.oTarget", oTarget, 0);
        bub = '0;
        iID = bub;
        @(negedge iClk);
        nRst = 1'b1;
        applyStimulus(mkId(ALU_ADD, 1'b0, 0, 0, 5, 7), 1'b1);
        #1;
        checkOutput("rstmid.idle", oStall, 0);
        @(posedge iClk);
        #1;
        checkOutput("rstmid.addRd", oME.rd.value, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute pipeline stage of the in-order RV32IM datapath. It sits between decode and the memory stage. It consumes the `id_ex_t` bundle, computes ALU results, effective addresses, branch/jump outcomes and M-extension results, and registers an `ex_mem_t` bundle for the memory stage. Multiply and divide run in a multi-cycle sub-unit, and the stage stalls upstream while that unit is busy.

## Interface
- `XLEN`, default 32: datapath width; all values below are for 32.
- `iClk` in 1: clock, rising edge.
- `nRst` in 1: asynchronous, active-low reset.
- `iEn` in 1: stage enable; low makes the current input a bubble.
- `iStall` in 1: downstream/hazard stall; holds `oME`.
- `iFlush` in 1: synchronous squash of `oME` and any in-flight mul/div.
- `iID` in `id_ex_t`: `ctrl` (`valid`, `alu_op`, `alu_src_imm`, `is_branch`, `is_jal`, `is_jalr`, `is_md`, `func3`, `mem_en`, `wb_en`), `pc`, `imm`, `rs1.value`, `rs2.value`, `rd.addr`.
- `oME` out `ex_mem_t`: `ctrl` (`valid`, `mem_en`, `wb_en`, `func3`), `rd.addr`, `rd.value`, `rs.value`.
- `oStall` out 1: mul/div busy; upstream must hold `iID`.
- `oBranch` out 1: redirect taken this cycle.
- `oTarget` out 32: redirect PC.

## Operation
- Operand B is `imm` when `alu_src_imm` is set, otherwise `rs2.value`. Operand A is `rs1.value`.
- ALU ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB (LUI), ADDPC (AUIPC uses `pc` as A). Shift amount is B[4:0].
- Loads and stores: `rd.value` is rs1+imm (the effective address), and `rs.value` is `rs2.value`. A store has `mem_en`=1 and `wb_en`=0; a load has `mem_en`=1 and `wb_en`=1.
- JAL/JALR: `rd.value` = pc+4. Target is pc+imm for JAL, and (rs1+imm)&~1 for JALR.
- Branches: the compare is selected by func3 (BEQ, BNE, BLT, BGE, BLTU, BGEU); target is pc+imm.
- `oBranch` is combinational: (jump, or branch with a true compare) & `ctrl.valid` & `iEn` & ~`iStall` & ~`oStall`.
- M-extension: `is_md` with func3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
  - Divide by zero: quotient = all ones, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
  - Both special cases go straight to DONE.
- Mul/div FSM states and transitions:
  - IDLE -> MUL or DIV when a valid md op arrives and `iEn`=1.
  - MUL -> DONE after 1 cycle (registered product).
  - DIV -> DONE after 32 cycles of restoring iterations, with signs fixed up at the end.
  - DONE -> IDLE when `oME` captures, i.e. on a posedge with `iStall`=0.
- `oStall`: 1 in IDLE while a valid md op is on the input, 1 in MUL and DIV, 0 in DONE.
- Output register priority: reset > flush > stall.
  - `nRst`=0: `oME`='0, FSM goes to IDLE.
  - `iFlush`: `oME`='0, FSM goes to IDLE; an in-flight divide is abandoned.
  - `iStall` or `oStall`: `oME` holds.
  - Otherwise `oME` loads the result, with `ctrl.valid` = `iID.ctrl.valid & iEn`.
- While `iStall` is high, MUL/DIV keep counting and DONE holds its result.

## Timing
- Non-md ops: 1-cycle latency, input to `oME` on the next posedge.
- MUL family: 2 stall cycles later, the result enters `oME` on the third posedge after arrival.
- DIV family: 33 stall cycles, the result enters `oME` on the 34th posedge. Special cases: 1 stall cycle.
- Reset values: `oME`=0, `oStall`=0, `oBranch`=0, `oTarget`=0. `oTarget` is don't-care whenever `oBranch`=0.
- `iFlush` and `iStall` in the same cycle: the flush wins.

## Structure
- `pipeline_types` gains:
  - `id_ex_t` and `ex_ctrl_t`;
  - `alu_op_e`;
  - the `md_op` func3 constants;
  - the `ex_mem_t` ctrl fields listed above.
- Sub-module `muldiv_unit` has inputs start, op, a, b, flush; outputs busy, done, result; and holds the FSM and the iteration counter. The stage holds the ALU, branch compare and output register.

## Test plan
- ADD with rs1=5, rs2=7 -> `oME.rd.value`=12 and `valid`=1 one cycle later. SRA of 0x80000000 by 4 -> 0xF8000000.
- BEQ with equal operands, pc=0x100, imm=0x20 -> `oBranch`=1 and `oTarget`=0x120 in the same cycle. JALR with rs1=0x203, imm=0 -> target 0x202 and `rd.value` = pc+4.
- DIV of -7 by 2 -> `oStall` high for 33 cycles, then quotient -3; REM of the same operands -> -1. DIV of 0x80000000 by -1 -> 0x80000000 with 1 stall cycle. DIVU of x by 0 -> 0xFFFFFFFF.
- MULHU of 0xFFFFFFFF by 0xFFFFFFFF -> 0xFFFFFFFE after 2 stall cycles. With `iStall` held 5 cycles in DONE, the result is kept and `oME` is unchanged until release.
- `iFlush` at cycle 10 of a DIV -> `oME`=0, `oStall` drops the next cycle, and a following ADD completes normally.
- Store (`mem_en`=1, `wb_en`=0) with rs1=0x1000, imm=8 -> `rd.value`=0x1008 and `rs.value`=rs2. `nRst` pulsed mid-DIV -> all outputs 0 immediately.
